// File: rtl/switch_mcu_ex_upper_imm.sv
// U-type execute unit: computes LUI/AUIPC results and buffers them in a small
// writeback FIFO that drains into the register file under in_wready backpressure.
module switch_mcu_ex_upper_imm #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned DEPTH   = 2,
    parameter int unsigned PC_OFS  = 4,
    parameter int unsigned X0_DROP = 1
) (
    input  logic                         in_clk,
    input  logic                         in_rst,
    input  logic                         in_flush,
    input  logic                         in_valid,
    output logic                         out_in_ready,
    input  logic [XLEN-1:0]              in_pc_reg,
    input  logic                         in_lui,
    input  logic                         in_auipc,
    input  logic [19:0]                  in_imm_type_u,
    input  logic [4:0]                   in_rd,
    output logic                         out_wvalid,
    input  logic                         in_wready,
    output logic [4:0]                   out_waddr,
    output logic                         out_wen,
    output logic [XLEN-1:0]              out_wdata,
    output logic                         out_err,
    output logic [$clog2(DEPTH):0]       out_count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [4:0]      mem_rd   [DEPTH];
    logic [XLEN-1:0] mem_data [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             err_q;

    logic             accept;
    logic             illegal;
    logic             enq;
    logic             deq;
    logic             rd_is_x0;
    logic [31:0]      base32;
    logic [XLEN-1:0]  base;
    logic [XLEN-1:0]  result;

    // Handshake and classification of the offered op
    always_comb begin
        accept   = in_valid && out_in_ready && !in_flush;
        illegal  = in_lui && in_auipc;
        rd_is_x0 = (X0_DROP != 0) && (in_rd == 5'd0);
        enq      = accept && (in_lui ^ in_auipc) && !rd_is_x0;
        deq      = out_wvalid && in_wready;
    end

    // Upper-immediate datapath; base is sign-extended from bit 31
    always_comb begin
        base32 = {in_imm_type_u, 12'b0};
        base   = XLEN'($signed(base32));
        result = base;
        if (in_auipc) begin
            result = base + in_pc_reg - XLEN'(PC_OFS);
        end
    end

    // Queue control: pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            err_q  <= 1'b0;
        end else begin
            err_q <= accept && illegal;
            if (in_flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (enq) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (deq) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                count <= count + CNT_W'(enq) - CNT_W'(deq);
            end
        end
    end

    // Entry storage needs no reset: contents are masked while count is zero
    always_ff @(posedge in_clk) begin
        if (enq) begin
            mem_rd[wr_ptr]   <= in_rd;
            mem_data[wr_ptr] <= result;
        end
    end

    // Write port is driven only from registered state
    always_comb begin
        out_count    = count;
        out_in_ready = (count != CNT_W'(DEPTH));
        out_wvalid   = (count != '0);
        out_wen      = out_wvalid;
        out_err      = err_q;
        out_waddr    = '0;
        out_wdata    = '0;
        if (out_wvalid) begin
            out_waddr = mem_rd[rd_ptr];
            out_wdata = mem_data[rd_ptr];
        end
    end

endmodule
